// File: rtl/or1200_keccak_cust5_pkg.sv
// or1200_keccak_cust5_pkg: shared sizes, l.cust5 Keccak opcodes and FSM states
package or1200_keccak_cust5_pkg;
    localparam int CUST5_DW = 32;
    localparam int CUST5_DIGEST_WORDS = 16;
    localparam logic [4:0] OP_START  = 5'b00100;
    localparam logic [4:0] OP_MIDDLE = 5'b00010;
    localparam logic [4:0] OP_END    = 5'b00001;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    typedef enum logic [1:0] {IDLE, ABSORB, SQZ_WAIT, DIGEST_VALID} state_t;
    function automatic logic state_busy(state_t s);
        return s == ABSORB || s == SQZ_WAIT;
    endfunction
endpackage

// File: rtl/or1200_keccak_cust5_if.sv
// or1200_keccak_cust5_if: handshake between the cust5 unit (master) and the Keccak core (slave)
//   init      one-cycle core state clear
//   in_valid / in_ready / in_data / in_last   message word stream
//   out_valid / out_data                      digest pulse, word i at [W*i +: W]
interface or1200_keccak_cust5_if
    import or1200_keccak_cust5_pkg::*;
#(
    parameter int W = CUST5_DW,
    parameter int N = CUST5_DIGEST_WORDS
);
    logic init;
    logic in_valid;
    logic in_last;
    logic in_ready;
    logic out_valid;
    logic [W-1:0] in_data;
    logic [W*N-1:0] out_data;
    modport master (output init, in_valid, in_data, in_last, input in_ready, out_valid, out_data);
    modport slave (input init, in_valid, in_data, in_last, output in_ready, out_valid, out_data);
endinterface

// File: rtl/or1200_keccak_digest_rf.sv
// or1200_keccak_digest_rf: digest word bank with parallel load and asynchronous indexed read
//   clk, rst   clock, async active-high reset (bank cleared)
//   load, din  capture all N words from din
//   idx, dout  combinational read of word idx
module or1200_keccak_digest_rf
    import or1200_keccak_cust5_pkg::*;
#(
    parameter int DW = CUST5_DW,
    parameter int N = CUST5_DIGEST_WORDS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [DW*N-1:0]        din,
    input  logic [$clog2(N)-1:0]   idx,
    output logic [DW-1:0]          dout
);
    logic [DW-1:0] bank [N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) for (int i = 0; i < N; i++) bank[i] <= '0;
        else if (load) for (int i = 0; i < N; i++) bank[i] <= din[DW*i +: DW];
    end

    assign dout = bank[idx];
endmodule

// File: rtl/or1200_keccak_cust5_unit.sv
// or1200_keccak_cust5_unit: EX-stage l.cust5 unit streaming rA words to a Keccak core and returning digest words
//   clk, rst               clock, async active-high reset
//   ex_cust5, ex_freeze    valid l.cust5 in EX / EX frozen
//   cust5_op, cust5_limm   decoded op, immediate ([3:0] = STORE word index)
//   opa                    rA operand
//   cust5_result           RF writeback value
//   stall, busy, err       freeze request, absorbing/squeezing, sticky protocol error
//   kc                     Keccak core handshake (master side)
module or1200_keccak_cust5_unit
    import or1200_keccak_cust5_pkg::*;
#(
    parameter int DW = CUST5_DW,
    parameter int DIGEST_WORDS = CUST5_DIGEST_WORDS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_cust5,
    input  logic          ex_freeze,
    input  logic [4:0]    cust5_op,
    input  logic [5:0]    cust5_limm,
    input  logic [DW-1:0] opa,
    output logic [DW-1:0] cust5_result,
    output logic          stall,
    output logic          busy,
    output logic          err,
    or1200_keccak_cust5_if.master kc
);
    localparam int IW = $clog2(DIGEST_WORDS);

    state_t state, state_nxt;
    logic cmd_done;
    logic [DW-1:0] result_q, live_result, bank_word;
    logic [IW-1:0] idx;
    logic [5:IW] limm_unused;
    logic is_start, is_middle, is_end, is_store;
    logic pending, send, complete, fire, bad_op, sqz_hit;

    assign idx = cust5_limm[IW-1:0];
    assign limm_unused = cust5_limm[5:IW];
    assign is_start = cust5_op == OP_START;
    assign is_middle = cust5_op == OP_MIDDLE;
    assign is_end = cust5_op == OP_END;
    assign is_store = cust5_op == OP_STORE;

    // rst gates every combinational output so the core handshake drops the moment reset asserts
    assign pending = ex_cust5 && !cmd_done && !rst;
    assign sqz_hit = state == SQZ_WAIT && kc.out_valid;
    assign send = is_start || ((is_middle || is_end) && state == ABSORB);
    assign bad_op = ((is_middle || is_end) && state != ABSORB) ||
                    (is_store && (state == IDLE || state == ABSORB));
    assign complete = send ? kc.in_ready : (is_store && state == SQZ_WAIT) ? kc.out_valid : 1'b1;
    assign fire = pending && complete;
    assign stall = pending && !complete;

    assign kc.in_valid = pending && send;
    assign kc.in_last = kc.in_valid && is_end;
    assign kc.init = fire && is_start;
    assign kc.in_data = rst ? '0 : opa;

    // a STORE arriving in the digest cycle reads the core bus directly since the bank loads on the same edge
    assign live_result = !is_store ? '0 :
                         state == DIGEST_VALID ? bank_word :
                         sqz_hit ? kc.out_data[DW*idx +: DW] : '0;
    assign cust5_result = rst ? '0 : cmd_done ? result_q : live_result;

    // START restarts from any state and therefore wins over a digest arriving in the same cycle
    assign state_nxt = (fire && is_start) ? ABSORB :
                       (fire && is_end && state == ABSORB) ? SQZ_WAIT :
                       sqz_hit ? DIGEST_VALID : state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cmd_done <= 1'b0;
            result_q <= '0;
            busy <= 1'b0;
            err <= 1'b0;
        end else begin
            state <= state_nxt;
            busy <= state_busy(state_nxt);
            err <= err || (fire && bad_op);
            cmd_done <= ex_freeze && (cmd_done || fire);
            if (fire) result_q <= live_result;
        end
    end

    or1200_keccak_digest_rf #(.DW(DW), .N(DIGEST_WORDS)) u_digest_rf (
        .clk(clk),
        .rst(rst),
        .load(sqz_hit),
        .din(kc.out_data),
        .idx(idx),
        .dout(bank_word)
    );
endmodule

// File: tb/tb_or1200_keccak_cust5_unit.sv
// tb_or1200_keccak_cust5_unit: scoreboard bench for the l.cust5 Keccak unit with a behavioural core model
module tb_or1200_keccak_cust5_unit;
    import or1200_keccak_cust5_pkg::*;

    typedef struct {logic [31:0] res; logic err;} res_t;
    typedef struct {logic [31:0] data; logic last; logic init;} word_t;

    logic clk = 0, rst = 1, ex_cust5 = 0, ex_freeze = 0;
    logic [4:0] cust5_op = 0;
    logic [5:0] cust5_limm = 0;
    logic [31:0] opa = 0;
    logic [31:0] cust5_result;
    logic stall, busy, err;

    or1200_keccak_cust5_if #(.W(32), .N(16)) kc();

    or1200_keccak_cust5_unit #(.DW(32), .DIGEST_WORDS(16)) dut (
        .clk(clk), .rst(rst), .ex_cust5(ex_cust5), .ex_freeze(ex_freeze),
        .cust5_op(cust5_op), .cust5_limm(cust5_limm), .opa(opa),
        .cust5_result(cust5_result), .stall(stall), .busy(busy), .err(err), .kc(kc)
    );

    always #5 clk = ~clk;

    res_t rq[$];
    word_t wq[$];
    int checks = 0, errors = 0, cmd_id = 0, rdy_mode = 0;
    bit absorbing = 0, squeezing = 0, have_digest = 0, m_err = 0;
    logic [31:0] m_bank [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] d, input logic last, input logic init);
        word_t w;
        w.data = d; w.last = last; w.init = init;
        wq.push_back(w);
    endtask

    // core model: random backpressure unless the stimulus takes manual control
    initial forever begin
        @(posedge clk); #1;
        if (rdy_mode == 0) kc.in_ready = $urandom_range(0, 2) != 0;
    end

    // monitor: pops one expected result per command, compares every accepted word
    initial begin
        int seen_id = 0;
        bit err_due = 0;
        logic err_exp = 0;
        res_t cur;
        word_t w;
        cur.res = 0; cur.err = 0;
        forever begin
            @(negedge clk);
            if (err_due) begin
                check("err", 64'(err), 64'(err_exp));
                err_due = 0;
            end
            if (!rst && kc.in_valid && kc.in_ready) begin
                if (wq.size() == 0) begin
                    check("unexpected_word", 64'(kc.in_data), 64'hx);
                end else begin
                    w = wq.pop_front();
                    check("word", {kc.in_data, kc.in_last, kc.init}, {w.data, w.last, w.init});
                end
            end else if (kc.init) begin
                check("init_without_send", 64'(kc.in_valid && kc.in_ready), 64'd1);
            end
            if (!rst && ex_cust5 && !stall) begin
                if (cmd_id != seen_id) begin
                    seen_id = cmd_id;
                    if (rq.size() == 0) check("unexpected_result", 64'(cust5_result), 64'hx);
                    else begin
                        cur = rq.pop_front();
                        err_due = 1;
                        err_exp = cur.err;
                    end
                end
                check("result", 64'(cust5_result), 64'(cur.res));
            end
        end
    end

    task automatic random_digest(output logic [511:0] dg);
        for (int i = 0; i < 16; i++) dg[32*i +: 32] = $urandom;
    endtask

    task automatic take_digest(input logic [511:0] dg);
        for (int i = 0; i < 16; i++) m_bank[i] = dg[32*i +: 32];
        squeezing = 0;
        have_digest = 1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [5:0] limm, input logic [31:0] a,
                         input int fz, input int rdy_hold, input int sq_delay, input bit fix15,
                         output int stalls);
        res_t r;
        logic [511:0] dg;
        bit need_sq = 0;
        int n = 0;
        r.res = 0;
        random_digest(dg);
        if (fix15) dg[511:480] = 32'hDEADBEEF;
        case (op)
            OP_START: begin push_word(a, 0, 1); absorbing = 1; squeezing = 0; have_digest = 0; end
            OP_MIDDLE: if (absorbing) push_word(a, 0, 0); else m_err = 1;
            OP_END: if (absorbing) begin push_word(a, 1, 0); absorbing = 0; squeezing = 1; end
                    else m_err = 1;
            OP_STORE: if (have_digest) r.res = m_bank[limm[3:0]];
                      else if (squeezing) begin need_sq = 1; take_digest(dg); r.res = m_bank[limm[3:0]]; end
                      else m_err = 1;
            default: ;
        endcase
        r.err = m_err;
        rq.push_back(r);
        @(posedge clk); #1;
        ex_cust5 = 1; cust5_op = op; cust5_limm = limm; opa = a; ex_freeze = fz > 0;
        cmd_id++;
        if (rdy_hold >= 0) begin rdy_mode = 1; kc.in_ready = rdy_hold == 0; end
        forever begin
            if (need_sq && n == sq_delay) begin kc.out_valid = 1; kc.out_data = dg; end
            @(negedge clk);
            if (!stall) break;
            n++;
            if (n > 300) begin check("complete_timeout", 64'(n), 64'(0)); break; end
            @(posedge clk); #1;
            if (rdy_hold >= 0) kc.in_ready = n >= rdy_hold;
        end
        stalls = n;
        @(posedge clk); #1;
        kc.out_valid = 0;
        if (fz > 0) begin
            repeat (fz - 1) begin @(posedge clk); #1; end
            ex_freeze = 0;
            @(posedge clk); #1;
        end
        ex_cust5 = 0; cust5_op = 0;
        if (rdy_hold >= 0) rdy_mode = 0;
        @(negedge clk);
        check("busy", 64'(busy), 64'(absorbing || squeezing));
    endtask

    // digest pulse between commands; only meaningful while a digest is awaited
    task automatic gap_pulse();
        logic [511:0] dg;
        random_digest(dg);
        @(posedge clk); #1;
        kc.out_valid = 1; kc.out_data = dg;
        @(posedge clk); #1;
        kc.out_valid = 0;
        if (squeezing) take_digest(dg);
    endtask

    initial begin
        int st;
        kc.in_ready = 0; kc.out_valid = 0; kc.out_data = '0;
        for (int i = 0; i < 16; i++) m_bank[i] = 0;
        ex_cust5 = 1; cust5_op = OP_START; opa = 32'h5;
        @(negedge clk);
        check("rst_stall", 64'(stall), 0);
        check("rst_in_valid", 64'(kc.in_valid), 0);
        check("rst_init", 64'(kc.init), 0);
        check("rst_in_data", 64'(kc.in_data), 0);
        check("rst_result", 64'(cust5_result), 0);
        check("rst_busy_err", {busy, err}, 0);
        @(posedge clk); #1;
        ex_cust5 = 0; cust5_op = 0; rst = 0;

        issue(OP_START, 0, 32'd1, 0, 0, 0, 0, st);
        check("start_stalls", 64'(st), 0);
        issue(OP_MIDDLE, 0, 32'd2, 0, 3, 0, 0, st);
        check("middle_stalls", 64'(st), 3);
        issue(OP_END, 0, 32'd4, 0, 0, 0, 0, st);
        issue(OP_STORE, 6'd15, 0, 0, -1, 3, 1, st);
        check("store_bypass_stalls", 64'(st), 3);
        for (int i = 0; i < 16; i++) begin
            issue(OP_STORE, 6'(i), 0, 0, -1, 0, 0, st);
            check("store_bank_stalls", 64'(st), 0);
        end
        issue(OP_STORE, 6'd7, 0, 4, -1, 0, 0, st);
        issue(OP_START, 0, 32'h9, 4, 0, 0, 0, st);

        repeat (300) begin
            int r, fz, sel;
            logic [4:0] op;
            sel = $urandom_range(0, 99);
            if (sel < 18) op = OP_START;
            else if (sel < 48) op = OP_MIDDLE;
            else if (sel < 62) op = OP_END;
            else if (sel < 88) op = OP_STORE;
            else do op = 5'($urandom); while (op == OP_START || op == OP_MIDDLE || op == OP_END || op == OP_STORE);
            fz = $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0;
            r = $urandom_range(0, 3);
            issue(op, 6'($urandom), $urandom, fz, -1, r, 0, st);
            if ($urandom_range(0, 9) == 0) gap_pulse();
        end

        issue(OP_START, 0, $urandom, 0, 0, 0, 0, st);
        @(posedge clk); #1;
        rdy_mode = 1; kc.in_ready = 0;
        ex_cust5 = 1; cust5_op = OP_MIDDLE; opa = 32'h123;
        @(negedge clk);
        check("wait_stall", 64'(stall), 1);
        check("wait_in_valid", 64'(kc.in_valid), 1);
        #2 rst = 1;
        #1;
        check("midrst_stall_valid", {stall, kc.in_valid, kc.in_last, kc.init}, 0);
        check("midrst_in_data", 64'(kc.in_data), 0);
        check("midrst_result", 64'(cust5_result), 0);
        check("midrst_busy_err", {busy, err}, 0);
        ex_cust5 = 0; cust5_op = 0;
        absorbing = 0; squeezing = 0; have_digest = 0; m_err = 0;
        wq.delete();
        repeat (2) @(posedge clk);
        #1 rst = 0; rdy_mode = 0;

        issue(OP_MIDDLE, 0, 32'h7, 0, -1, 0, 0, st);
        repeat (3) @(negedge clk);
        check("results_left", 64'(rq.size()), 0);
        check("words_left", 64'(wq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
